// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP lane scheduler.
package bcp_pkg;

  localparam int unsigned N_LANES       = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned LIT_W_DEFAULT = 16;

  // Implied literal: variable index plus polarity bit.
  typedef logic [LIT_W_DEFAULT-1:0] lit_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HOLD = 3'd2,
    ST_CONF = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import bcp_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan lanes starting at ptr; modulo-8 wrap comes from the 3-bit add.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      cand = ptr + SEL_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/bcp_lane_scheduler.sv
// Round-robin scheduler for the 8 BCP clause-evaluation lanes: issues one
// implied literal at a time over valid/ready and ends the round on a conflict.
module bcp_lane_scheduler
  import bcp_pkg::*;
#(
  parameter int unsigned LIT_W = LIT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [N_LANES-1:0]         req_i,
  input  logic [N_LANES*LIT_W-1:0]   lit_i,
  input  logic [N_LANES-1:0]         conflict_i,
  output logic [SEL_W-1:0]           sel_o,
  output logic [N_LANES-1:0]         grant_o,
  output logic                       imp_valid_o,
  output logic [LIT_W-1:0]           imp_lit_o,
  input  logic                       imp_ready_i,
  output logic                       done_o,
  output logic                       conflict_o,
  output logic [SEL_W-1:0]           conflict_lane_o,
  output logic [7:0]                 issued_cnt_o
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_LANES-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [LIT_W-1:0]   lit_q, lit_d;
  logic               done_q, done_d;
  logic               conf_q, conf_d;
  logic [SEL_W-1:0]   conf_lane_q, conf_lane_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               conf_any;
  logic [SEL_W-1:0]   conf_idx;

  rr_pick8 u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Lowest-index conflicting lane.
  always_comb begin
    conf_any = 1'b0;
    conf_idx = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (!conf_any && conflict_i[i]) begin
        conf_any = 1'b1;
        conf_idx = SEL_W'(i);
      end
    end
  end

  // Next-state logic for the round FSM and all output registers.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant_d     = '0;
    valid_d     = valid_q;
    lit_d       = lit_q;
    done_d      = 1'b0;
    conf_d      = conf_q;
    conf_lane_d = conf_lane_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          ptr_d   = '0;
          conf_d  = 1'b0;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (conf_any) begin
          conf_lane_d = conf_idx;
          state_d     = ST_CONF;
        end else if (pick_any) begin
          sel_d   = pick_idx;
          lit_d   = lit_i[pick_idx*LIT_W +: LIT_W];
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_HOLD: begin
        // Conflicts are not looked at here; the offer is never withdrawn.
        if (imp_ready_i) begin
          grant_d[sel_q] = 1'b1;
          ptr_d          = sel_q + 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 8'd1;
          valid_d        = 1'b0;
          state_d        = ST_ARB;
        end
      end
      ST_CONF: begin
        conf_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      grant_q     <= '0;
      valid_q     <= 1'b0;
      lit_q       <= '0;
      done_q      <= 1'b0;
      conf_q      <= 1'b0;
      conf_lane_q <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      valid_q     <= valid_d;
      lit_q       <= lit_d;
      done_q      <= done_d;
      conf_q      <= conf_d;
      conf_lane_q <= conf_lane_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign sel_o           = sel_q;
  assign grant_o         = grant_q;
  assign imp_valid_o     = valid_q;
  assign imp_lit_o       = lit_q;
  assign done_o          = done_q;
  assign conflict_o      = conf_q;
  assign conflict_lane_o = conf_lane_q;
  assign issued_cnt_o    = cnt_q;

endmodule
